dmem_responder: RTL

Data-memory responder on the far side of the memory stage's load/store request interface. Accepts one word request at a time over a valid/ready handshake, models a configurable number of wait states, and performs the read or byte-masked write on an internal word array. Returns a response over a second valid/ready handshake. busy feeds the pipeline's stall_from_memory path.

---
 rtl/dmem_responder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one word request at a time, LATENCY wait states, byte-masked writes.
// Optional build macro DMEM_RANGE_CHECK_EN flags and suppresses accesses beyond the array.
module dmem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_sel_q, rd_sel_d;
  logic        err_q, err_d;

  logic [3:0][7:0] mem [DEPTH];
  logic [31:0]     rd_word_q;

  logic                  acc_fire;
  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_be;
  logic [31:0]           acc_off;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_oor;
  logic                  unused_off_bits;

  assign acc_off = acc_addr - BASE_ADDR;
  assign acc_idx = acc_off[DEPTH_LOG2+1:2];
  assign unused_off_bits = ^{acc_off[31:DEPTH_LOG2+2], acc_off[1:0]};

`ifdef DMEM_RANGE_CHECK_EN
  assign acc_oor = |acc_off[31:DEPTH_LOG2+2];
`else
  assign acc_oor = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rd_sel_d  = rd_sel_q;
    err_d     = err_q;
    acc_fire  = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          // Zero-latency accesses use the live request, not the not-yet-loaded capture regs.
          acc_we    = req_we;
          acc_addr  = req_addr;
          acc_wdata = req_wdata;
          acc_be    = req_be;
          if (LATENCY == 0) begin
            acc_fire = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          acc_fire = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (acc_fire) begin
      rd_sel_d = !acc_we && !acc_oor;
      err_d    = acc_oor;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      rd_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rd_sel_q <= rd_sel_d;
      err_q    <= err_d;
    end
  end

  // Array and its read register carry no reset; a write on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (acc_fire && !rst && !acc_oor) begin
      if (acc_we) begin
        for (int b = 0; b < 4; b++) begin
          if (acc_be[b]) mem[acc_idx][b] <= acc_wdata[b*8 +: 8];
        end
      end else begin
        rd_word_q <= mem[acc_idx];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = (resp_valid && rd_sel_q) ? rd_word_q : 32'd0;
  assign resp_err   = resp_valid && err_q;

endmodule
